// File: rtl/data_memory_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_memory_param                                            |
// | Description : Parametrised word-addressed data memory for the single-cycle |
// |               core. Byte-lane write strobes, registered 1-cycle reads with |
// |               a valid pulse, power-up clear sequencing and out-of-range    |
// |               address detection.                                           |
// | Macro       : DATAMEM_BYPASS_EN - when defined, a read and a write to the  |
// |               same address in one cycle return write-first data per lane;  |
// |               otherwise the read returns the pre-write word.               |
// | Ports       : clk, rst_n (sync, active-low)                                |
// |               mem_write, mem_read      request strobes                     |
// |               endereco [ADDR_W]        word address                        |
// |               byte_en [DATA_W/8]       write lane strobes                  |
// |               valor_escrita [DATA_W]   write data                          |
// |               valor_saida [DATA_W]     registered read data                |
// |               valor_valido             read-complete pulse                 |
// |               pronto                   1 = accepting requests              |
// |               erro_endereco            out-of-range request pulse          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_memory_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mem_write,
   input  logic                mem_read,
   input  logic [ADDR_W-1:0]   endereco,
   input  logic [DATA_W/8-1:0] byte_en,
   input  logic [DATA_W-1:0]   valor_escrita,
   output logic [DATA_W-1:0]   valor_saida,
   output logic                valor_valido,
   output logic                pronto,
   output logic                erro_endereco
);

   localparam int c_LANES = DATA_W / 8;
   localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
   localparam logic [ADDR_W:0]    c_DEPTH = (ADDR_W + 1)'(DEPTH);
   localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [c_IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0]    mem_q [DEPTH];
   logic [DATA_W-1:0]    saida_q, saida_d;
   logic                 valido_q, valido_d;
   logic                 erro_q, erro_d;

   logic                 w_in_range;
   logic                 w_wr_en;
   logic [c_IDX_W-1:0]   w_idx;
   logic [DATA_W-1:0]    w_lane_mask;
   logic [DATA_W-1:0]    w_stored;
   logic [DATA_W-1:0]    w_merged;

   // Truncation is lossless whenever the address is in range; out-of-range
   // addresses never reach the array because every use is gated by w_in_range.
   assign w_in_range = ({1'b0, endereco} < c_DEPTH);
   assign w_idx      = endereco[c_IDX_W-1:0];
   assign w_stored   = w_in_range ? mem_q[w_idx] : '0;

   always_comb begin
      w_lane_mask = '0;
      for (int i = 0; i < c_LANES; i++) begin
         w_lane_mask[8*i +: 8] = {8{byte_en[i]}};
      end
   end

   assign w_merged = (w_stored & ~w_lane_mask) | (valor_escrita & w_lane_mask);
   assign w_wr_en  = (state_q == S_IDLE) && mem_write && w_in_range;

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      saida_d   = saida_q;
      valido_d  = 1'b0;
      erro_d    = 1'b0;
      case (state_q)
         S_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == c_LAST) begin
               state_d   = S_IDLE;
               clr_cnt_d = '0;
            end
         end
         S_IDLE: begin
            if (mem_read) begin
               valido_d = 1'b1;
               if (!w_in_range) begin
                  saida_d = '0;
               end
`ifdef DATAMEM_BYPASS_EN
               // Only one address port, so read+write is always same-address.
               else if (mem_write) begin
                  saida_d = w_merged;
               end
`endif
               else begin
                  saida_d = w_stored;
               end
            end
            erro_d = (mem_read || mem_write) && !w_in_range;
         end
         default: begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= '0;
         saida_q   <= '0;
         valido_q  <= 1'b0;
         erro_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         saida_q   <= saida_d;
         valido_q  <= valido_d;
         erro_q    <= erro_d;
      end
   end

   // Storage has no reset of its own; the clear sequence zeroes it instead,
   // so a cycle with rst_n low neither clears nor writes.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == S_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
         end else if (w_wr_en) begin
            mem_q[w_idx] <= w_merged;
         end
      end
   end

   assign valor_saida   = saida_q;
   assign valor_valido  = valido_q;
   assign erro_endereco = erro_q;
   assign pronto        = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_memory_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_memory_param                                         |
// | Description : Scoreboard bench for data_memory_param. Instance A uses the  |
// |               default 64-word geometry, instance B has DEPTH=40 to expose  |
// |               out-of-range handling. Both share the same stimulus.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_memory_param;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, mem_write, mem_read;
   logic [5:0]  endereco;
   logic [3:0]  byte_en;
   logic [31:0] valor_escrita;
   logic [31:0] saida_a, saida_b;
   logic        vld_a, vld_b, pr_a, pr_b, err_a, err_b;

   data_memory_param #(.DATA_W(32), .ADDR_W(6), .DEPTH(64)) dut_a (
      .clk(clk), .rst_n(rst_n), .mem_write(mem_write), .mem_read(mem_read),
      .endereco(endereco), .byte_en(byte_en), .valor_escrita(valor_escrita),
      .valor_saida(saida_a), .valor_valido(vld_a), .pronto(pr_a),
      .erro_endereco(err_a)
   );

   data_memory_param #(.DATA_W(32), .ADDR_W(6), .DEPTH(40)) dut_b (
      .clk(clk), .rst_n(rst_n), .mem_write(mem_write), .mem_read(mem_read),
      .endereco(endereco), .byte_en(byte_en), .valor_escrita(valor_escrita),
      .valor_saida(saida_b), .valor_valido(vld_b), .pronto(pr_b),
      .erro_endereco(err_b)
   );

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   logic [31:0] model [64];
   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_pass = 0;
   bit          mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
   endtask

   // Each expected read result is tagged with the clock edge it must appear on.
   always @(negedge clk) begin
      if (mon_en) begin
         if (qa.size() > 0 && qa[0].c == cyc) begin
            check("a_valid", 32'(vld_a), 32'd1);
            check("a_data", saida_a, qa[0].d);
            void'(qa.pop_front());
         end else begin
            check("a_novalid", 32'(vld_a), 32'd0);
         end
         if (qb.size() > 0 && qb[0].c == cyc) begin
            check("b_valid", 32'(vld_b), 32'd1);
            check("b_data", saida_b, qb[0].d);
            void'(qb.pop_front());
         end else begin
            check("b_novalid", 32'(vld_b), 32'd0);
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      mem_write = 1'b0;
      mem_read  = 1'b0;
      mon_en    = 1'b1;
      check("rst_saida", saida_a, 32'd0);
      check("rst_valid", 32'(vld_a), 32'd0);
      check("rst_pronto_a", 32'(pr_a), 32'd0);
      check("rst_pronto_b", 32'(pr_b), 32'd0);
      check("rst_erro_b", 32'(err_b), 32'd0);
      qa.delete();
      qb.delete();
      foreach (model[i]) model[i] = 32'h0;
      rst_n = 1'b1;
   endtask

   task automatic wait_clear();
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         check("clr_pronto_a", 32'(pr_a), 32'(k == 64));
         check("clr_pronto_b", 32'(pr_b), 32'(k >= 40));
      end
   endtask

   task automatic req(input bit we, input bit re, input logic [5:0] a,
                      input logic [3:0] be, input logic [31:0] d);
      logic [31:0] mask, merged, rd;
      mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      merged = (model[a] & ~mask) | (d & mask);
      rd     = model[a];
`ifdef DATAMEM_BYPASS_EN
      if (we) rd = merged;
`endif
      mem_write     = we;
      mem_read      = re;
      endereco      = a;
      byte_en       = be;
      valor_escrita = d;
      if (re) begin
         qa.push_back('{rd, cyc + 1});
         qb.push_back('{(a < 6'd40) ? rd : 32'h0, cyc + 1});
      end
      if (we) model[a] = merged;
      @(negedge clk);
      check("a_erro", 32'(err_a), 32'd0);
      check("b_erro", 32'(err_b), 32'((we || re) && a >= 6'd40));
      mem_write = 1'b0;
      mem_read  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
      endereco = '0; byte_en = '0; valor_escrita = '0;
      @(negedge clk);
      do_reset();
      wait_clear();

      // Reset/clear wipes previously written data
      req(1, 0, 6'd5, 4'hF, 32'hFFFFFFFF);
      req(0, 1, 6'd5, 4'h0, 32'h0);
      @(negedge clk);
      do_reset();
      wait_clear();
      req(0, 1, 6'd5, 4'h0, 32'h0);

      // Byte lanes, including a no-op all-lanes-off write
      req(1, 0, 6'd10, 4'hF, 32'hA5A5A5A5);
      req(1, 0, 6'd10, 4'h5, 32'h3C3C3C3C);
      req(0, 1, 6'd10, 4'h0, 32'h0);
      req(1, 0, 6'd10, 4'h0, 32'hFFFFFFFF);
      req(0, 1, 6'd10, 4'h0, 32'h0);

      // Back-to-back reads
      req(1, 0, 6'd20, 4'hF, 32'h11111111);
      req(1, 0, 6'd30, 4'hF, 32'hCAFEF00D);
      req(0, 1, 6'd10, 4'h0, 32'h0);
      req(0, 1, 6'd20, 4'h0, 32'h0);
      req(0, 1, 6'd30, 4'h0, 32'h0);
      @(negedge clk);

      // Same-cycle read and write, full and partial lanes
      req(1, 1, 6'd20, 4'hF, 32'h7E7E7E7E);
      req(0, 1, 6'd20, 4'h0, 32'h0);
      req(1, 1, 6'd30, 4'h3, 32'h0000BEEF);
      req(0, 1, 6'd30, 4'h0, 32'h0);

      // Out-of-range on the 40-word instance; no aliasing into low words
      req(1, 0, 6'd45, 4'hF, 32'hDEADBEEF);
      req(0, 1, 6'd45, 4'h0, 32'h0);
      req(0, 1, 6'd63, 4'h0, 32'h0);
      for (int a = 0; a < 40; a++) req(0, 1, 6'(a), 4'h0, 32'h0);
      @(negedge clk);

      // Reset mid-clear, with a read dropped by the first reset edge
      mem_read = 1'b1;
      endereco = 6'd10;
      do_reset();
      repeat (30) @(negedge clk);
      do_reset();
      wait_clear();
      req(0, 1, 6'd10, 4'h0, 32'h0);
      req(0, 1, 6'd30, 4'h0, 32'h0);
      repeat (2) @(negedge clk);

      check("qa_drained", 32'(qa.size()), 32'd0);
      check("qb_drained", 32'(qb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
